tournament_predictor_p: RTL and testbench



---
 rtl/tournament_predictor_p.sv | 186 ++++++++++++++++++
 tb/tb_tournament_predictor_p.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tournament_predictor_p.sv
// Tournament branch predictor: per-PC local history + gselect global PHT, chosen by a
// GHR-indexed chooser. One-cycle registered lookup, separate non-speculative update port.
module tournament_predictor_p #(
  parameter int PC_W        = 32,
  parameter int GHR_W       = 12,
  parameter int LHT_ENTRIES = 1024,
  parameter int LHIST_W     = 10,
  parameter int GIDX_W      = 12,
  parameter int GSEL_HIST   = 6,
  parameter int CTR_W       = 2
) (
  input  logic               clock,
  input  logic               reset,
  output logic               ready,
  input  logic               pred_valid,
  input  logic [PC_W-1:0]    pred_pc,
  output logic               pred_out_valid,
  output logic               pred_taken,
  output logic               pred_local,
  output logic               pred_global,
  output logic [GHR_W-1:0]   pred_ghist,
  output logic [LHIST_W-1:0] pred_lhist,
  input  logic               upd_valid,
  input  logic [PC_W-1:0]    upd_pc,
  input  logic               upd_taken,
  input  logic               upd_pred,
  input  logic               upd_local,
  input  logic               upd_global,
  input  logic [GHR_W-1:0]   upd_ghist,
  input  logic [LHIST_W-1:0] upd_lhist
);

  // Valid semantics: there is no backpressure. While ready is high every cycle with
  // pred_valid set is a lookup whose result pulses pred_out_valid on the next edge, and
  // every cycle with upd_valid set is a training event; both are dropped while ready is low.

  localparam int LHT_IDX_W = $clog2(LHT_ENTRIES);
  localparam int LPHT_D    = 1 << LHIST_W;
  localparam int GPHT_D    = 1 << GIDX_W;
  localparam int CHO_D     = 1 << GHR_W;
  localparam int MAXD_A    = (LHT_ENTRIES > LPHT_D) ? LHT_ENTRIES : LPHT_D;
  localparam int MAXD_B    = (GPHT_D > CHO_D) ? GPHT_D : CHO_D;
  localparam int MAXD      = (MAXD_A > MAXD_B) ? MAXD_A : MAXD_B;
  localparam int IDX_W     = $clog2(MAXD);
  localparam int PCB_W     = GIDX_W - GSEL_HIST;

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAXD - 1);
  localparam logic [IDX_W:0]   LHT_LIM  = (IDX_W + 1)'(LHT_ENTRIES);
  localparam logic [IDX_W:0]   LPHT_LIM = (IDX_W + 1)'(LPHT_D);
  localparam logic [IDX_W:0]   GPHT_LIM = (IDX_W + 1)'(GPHT_D);
  localparam logic [IDX_W:0]   CHO_LIM  = (IDX_W + 1)'(CHO_D);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   init_idx, idx_next;
  logic [GHR_W-1:0]   ghr;

  logic [LHIST_W-1:0] lht     [LHT_ENTRIES];
  logic [CTR_W-1:0]   lpht    [LPHT_D];
  logic [CTR_W-1:0]   gpht    [GPHT_D];
  logic [CTR_W-1:0]   chooser [CHO_D];

  function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] cur, input logic up);
    logic [CTR_W-1:0] res;
    res = cur;
    if (up) begin
      if (cur != {CTR_W{1'b1}}) res = cur + 1'b1;
    end else begin
      if (cur != {CTR_W{1'b0}}) res = cur - 1'b1;
    end
    return res;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state    <= state_next;
      init_idx <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = init_idx;
    case (state)
      INIT: begin
        idx_next = init_idx + 1'b1;
        if (init_idx == IDX_LAST) state_next = RUN;
      end
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  assign ready = (state == RUN);

  // ---------------- lookup path ----------------
  logic [LHT_IDX_W-1:0] lk_lht_idx;
  logic [LHIST_W-1:0]   lk_lhist;
  logic [GIDX_W-1:0]    lk_gidx;
  logic                 lk_local, lk_global, lk_choose, lk_taken;

  assign lk_lht_idx = pred_pc[2 +: LHT_IDX_W];
  assign lk_lhist   = lht[lk_lht_idx];
  assign lk_local   = lpht[lk_lhist][CTR_W-1];
  assign lk_gidx    = {ghr[GSEL_HIST-1:0], pred_pc[2 +: PCB_W]};
  assign lk_global  = gpht[lk_gidx][CTR_W-1];
  assign lk_choose  = chooser[ghr][CTR_W-1];
  assign lk_taken   = lk_choose ? lk_global : lk_local;

  // ---------------- update path ----------------
  logic [LHT_IDX_W-1:0] up_lht_idx;
  logic [GIDX_W-1:0]    up_gidx;
  logic [LHIST_W-1:0]   up_lht_old;
  logic [CTR_W-1:0]     up_lpht_old, up_gpht_old, up_cho_old;
  logic                 up_repair;

  assign up_lht_idx  = upd_pc[2 +: LHT_IDX_W];
  assign up_gidx     = {upd_ghist[GSEL_HIST-1:0], upd_pc[2 +: PCB_W]};
  assign up_lht_old  = lht[up_lht_idx];
  assign up_lpht_old = lpht[upd_lhist];
  assign up_gpht_old = gpht[up_gidx];
  assign up_cho_old  = chooser[upd_ghist];
  assign up_repair   = upd_valid && (upd_pred != upd_taken);

  // Table writes: the init sweep owns the tables until RUN; afterwards only the update port
  // writes them. Reads above see pre-edge contents, so a same-cycle lookup is read-before-write.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state == INIT) begin
        if ({1'b0, init_idx} < LHT_LIM)  lht[init_idx[LHT_IDX_W-1:0]]   <= '0;
        if ({1'b0, init_idx} < LPHT_LIM) lpht[init_idx[LHIST_W-1:0]]    <= CTR_INIT;
        if ({1'b0, init_idx} < GPHT_LIM) gpht[init_idx[GIDX_W-1:0]]     <= CTR_INIT;
        if ({1'b0, init_idx} < CHO_LIM)  chooser[init_idx[GHR_W-1:0]]   <= CTR_INIT;
      end else if (upd_valid) begin
        lht[up_lht_idx] <= {up_lht_old[LHIST_W-2:0], upd_taken};
        lpht[upd_lhist] <= ctr_next(up_lpht_old, upd_taken);
        gpht[up_gidx]   <= ctr_next(up_gpht_old, upd_taken);
        if (upd_local != upd_global)
          chooser[upd_ghist] <= ctr_next(up_cho_old, upd_global == upd_taken);
      end
    end
  end

  // ---------------- GHR and result registers ----------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      ghr            <= '0;
      pred_out_valid <= 1'b0;
      pred_taken     <= 1'b0;
      pred_local     <= 1'b0;
      pred_global    <= 1'b0;
      pred_ghist     <= '0;
      pred_lhist     <= '0;
    end else begin
      pred_out_valid <= 1'b0;
      if (state == RUN) begin
        if (pred_valid) begin
          pred_out_valid <= 1'b1;
          pred_taken     <= lk_taken;
          pred_local     <= lk_local;
          pred_global    <= lk_global;
          pred_ghist     <= ghr;
          pred_lhist     <= lk_lhist;
        end
        // A mispredict repair wins over the speculative shift of a same-cycle lookup.
        if (up_repair)
          ghr <= {upd_ghist[GHR_W-2:0], upd_taken};
        else if (pred_valid)
          ghr <= {ghr[GHR_W-2:0], lk_taken};
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc, upd_pc};

endmodule

// File: tb/tb_tournament_predictor_p.sv
// Directed bench for tournament_predictor_p with small table geometry (MAXD = 16):
// table of per-cycle vectors plus hand sequences for init and mid-run reset.
module tb_tournament_predictor_p;

  localparam int PC_W = 32;
  localparam int W    = 11;

  logic              clock = 1'b0;
  logic              reset;
  logic              ready;
  logic              pred_valid;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_out_valid, pred_taken, pred_local, pred_global;
  logic [3:0]        pred_ghist, pred_lhist;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken, upd_pred, upd_local, upd_global;
  logic [3:0]        upd_ghist, upd_lhist;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  tournament_predictor_p #(
    .PC_W(32), .GHR_W(4), .LHT_ENTRIES(16), .LHIST_W(4),
    .GIDX_W(4), .GSEL_HIST(2), .CTR_W(2)
  ) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken),
    .pred_local(pred_local), .pred_global(pred_global),
    .pred_ghist(pred_ghist), .pred_lhist(pred_lhist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .upd_local(upd_local), .upd_global(upd_global),
    .upd_ghist(upd_ghist), .upd_lhist(upd_lhist)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- vectors ----------------
  typedef struct packed {
    logic        pv;
    logic [31:0] ppc;
    logic        uv;
    logic [31:0] upc;
    logic        ut, upred, ul, ug;
    logic [3:0]  ugh, ulh;
    logic        e_ov, e_t, e_l, e_g;
    logic [3:0]  e_gh, e_lh;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(int pv, int ppc, int uv, int upc, int ut, int upred,
                              int ul, int ug, int ugh, int ulh,
                              int eov, int et, int el, int eg, int egh, int elh);
    vec_t v;
    v.pv = 1'(pv);   v.ppc = 32'(ppc); v.uv = 1'(uv); v.upc = 32'(upc);
    v.ut = 1'(ut);   v.upred = 1'(upred); v.ul = 1'(ul); v.ug = 1'(ug);
    v.ugh = 4'(ugh); v.ulh = 4'(ulh);
    v.e_ov = 1'(eov); v.e_t = 1'(et); v.e_l = 1'(el); v.e_g = 1'(eg);
    v.e_gh = 4'(egh); v.e_lh = 4'(elh);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    pred_valid = v.pv;  pred_pc   = v.ppc;
    upd_valid  = v.uv;  upd_pc    = v.upc;
    upd_taken  = v.ut;  upd_pred  = v.upred;
    upd_local  = v.ul;  upd_global = v.ug;
    upd_ghist  = v.ugh; upd_lhist = v.ulh;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_result();
    logic [W-1:0] e;
    if (pred_out_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got valid expected none (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("pred_taken",  32'(pred_taken),  32'(e[10]));
        check("pred_local",  32'(pred_local),  32'(e[9]));
        check("pred_global", 32'(pred_global), 32'(e[8]));
        check("pred_ghist",  32'(pred_ghist),  32'(e[7:4]));
        check("pred_lhist",  32'(pred_lhist),  32'(e[3:0]));
      end
    end
  endtask

  task automatic idle_inputs();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // ---------------- test ----------------
  initial begin
    //             pv ppc   uv upc   ut pr ul ug ugh ulh  ov t  l  g  gh   lh
    vecs[0]  = mk(1, 'h40, 0, 0,    0, 0, 0, 0, 0,  0,   1, 0, 0, 0, 0,   0);
    // train lPHT[0] and gPHT[1],[5],[13] toward taken
    vecs[1]  = mk(0, 0,    1, 'h54, 1, 1, 1, 1, 0,  0,   0, 0, 0, 0, 0,   0);
    vecs[2]  = mk(0, 0,    1, 'h54, 1, 1, 1, 1, 1,  0,   0, 0, 0, 0, 0,   0);
    vecs[3]  = mk(0, 0,    1, 'h54, 1, 1, 1, 1, 3,  0,   0, 0, 0, 0, 0,   0);
    // speculative GHR shifting
    vecs[4]  = mk(1, 'h44, 0, 0,    0, 0, 0, 0, 0,  0,   1, 1, 1, 1, 0,   0);
    vecs[5]  = mk(1, 'h44, 0, 0,    0, 0, 0, 0, 0,  0,   1, 1, 1, 1, 1,   0);
    vecs[6]  = mk(1, 'h44, 0, 0,    0, 0, 0, 0, 0,  0,   1, 1, 1, 1, 3,   0);
    // repair with same-cycle lookup, then lookup on repaired GHR
    vecs[7]  = mk(1, 'h40, 1, 'h60, 0, 1, 1, 1, 5,  'hE, 1, 1, 1, 0, 7,   0);
    vecs[8]  = mk(1, 'h40, 0, 0,    0, 0, 0, 0, 0,  0,   1, 1, 1, 0, 'hA, 0);
    // chooser[0] toward global, GHR repaired to 0
    vecs[9]  = mk(0, 0,    1, 'h60, 0, 1, 1, 0, 0,  'hE, 0, 0, 0, 0, 0,   0);
    vecs[10] = mk(1, 'h40, 0, 0,    0, 0, 0, 0, 0,  0,   1, 0, 1, 0, 0,   0);
    // saturation: five taken
    for (int i = 11; i <= 15; i++)
      vecs[i] = mk(0, 0,   1, 'h48, 1, 1, 1, 1, 0,  'hF, 0, 0, 0, 0, 0,   0);
    vecs[16] = mk(1, 'h48, 0, 0,    0, 0, 0, 0, 0,  0,   1, 1, 1, 1, 0,   'hF);
    // five not-taken, first one repairs GHR to 0
    vecs[17] = mk(0, 0,    1, 'h48, 0, 1, 0, 0, 0,  0,   0, 0, 0, 0, 0,   0);
    for (int i = 18; i <= 21; i++)
      vecs[i] = mk(0, 0,   1, 'h48, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0, 0,   0);
    vecs[22] = mk(1, 'h48, 0, 0,    0, 0, 0, 0, 0,  0,   1, 0, 0, 0, 0,   0);
    // back-to-back lookups
    vecs[23] = mk(1, 'h44, 0, 0,    0, 0, 0, 0, 0,  0,   1, 1, 0, 1, 0,   0);
    vecs[24] = mk(1, 'h44, 0, 0,    0, 0, 0, 0, 0,  0,   1, 0, 0, 1, 1,   0);

    // ---- reset and init sweep ----
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();
    check("rst_ready",  32'(ready),          32'(0));
    check("rst_ov",     32'(pred_out_valid), 32'(0));
    check("rst_taken",  32'(pred_taken),     32'(0));
    check("rst_local",  32'(pred_local),     32'(0));
    check("rst_global", 32'(pred_global),    32'(0));
    check("rst_ghist",  32'(pred_ghist),     32'(0));
    check("rst_lhist",  32'(pred_lhist),     32'(0));

    reset      = 1'b1;
    pred_valid = 1'b1;
    pred_pc    = 32'h40;
    upd_valid  = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("init_ready", 32'(ready),          32'(k == 16));
      check("init_ov",    32'(pred_out_valid), 32'(0));
    end

    // ---- table-driven run ----
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      if (vecs[i].e_ov)
        exp_q.push_back({vecs[i].e_t, vecs[i].e_l, vecs[i].e_g, vecs[i].e_gh, vecs[i].e_lh});
      tick();
      check($sformatf("v%0d_ready", i), 32'(ready),          32'(1));
      check($sformatf("v%0d_ov", i),    32'(pred_out_valid), 32'(vecs[i].e_ov));
      check_result();
    end
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    // ---- reset in the middle of back-to-back lookups ----
    idle_inputs();
    reset      = 1'b0;
    pred_valid = 1'b1;
    pred_pc    = 32'h44;
    tick();
    check("mid_rst_ov",    32'(pred_out_valid), 32'(0));
    check("mid_rst_ready", 32'(ready),          32'(0));
    check("mid_rst_taken", 32'(pred_taken),     32'(0));
    check("mid_rst_ghist", 32'(pred_ghist),     32'(0));

    reset   = 1'b1;
    pred_pc = 32'h40;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("reinit_ready", 32'(ready),          32'(k == 16));
      check("reinit_ov",    32'(pred_out_valid), 32'(0));
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
    tick();
    check("reinit_look_ov", 32'(pred_out_valid), 32'(1));
    check_result();
    pred_valid = 1'b0;
    tick();
    check("pulse_ov", 32'(pred_out_valid), 32'(0));
    check("final_queue", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
